// File: rtl/imem_pkg.sv
// Shared types for the instruction-memory server: word type, FSM states,
// response payload and the filler word returned for unloaded or bad fetches.
package imem_pkg;

    typedef logic [31:0] inst_t;

    typedef enum logic {
        LOAD  = 1'b0,
        SERVE = 1'b1
    } imem_state_e;

    typedef struct packed {
        inst_t inst;
        logic  err;
    } imem_rsp_t;

    localparam inst_t NOP_WORD = 32'h0000_0000;

endpackage

// File: rtl/imem_ram.sv
// DEPTH x 32 instruction store: one write port, one registered read port.
// The read register only updates on rd_en, so a response held under
// back-pressure keeps its data without extra storage.
module imem_ram
    import imem_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  inst_t            wr_data,
    input  logic             rd_en,
    input  logic [IDX_W-1:0] rd_idx,
    output inst_t            rd_data
);

    inst_t mem [DEPTH];

    // Image write port, used only while loading.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // Registered read port, captured when a fetch is accepted.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_idx];
        end
    end

endmodule

// File: rtl/imem_server.sv
// Instruction-memory responder. LOAD accepts a word stream into the store;
// SERVE answers fetches with one-cycle latency through a single response
// register.
// Handshake: a transfer happens on a rising clk edge where valid && ready;
// valid, once raised, holds with its payload stable until that edge, and
// ready may depend combinationally on the consumer's ready (req_ready does
// on rsp_ready).
module imem_server
    import imem_pkg::*;
#(
    parameter int    DEPTH    = 1024,
    parameter int    IDX_W    = $clog2(DEPTH),
    parameter inst_t NOP_WORD = imem_pkg::NOP_WORD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             reload,
    input  logic             ld_valid,
    input  logic [31:0]      ld_data,
    input  logic             ld_last,
    output logic             ld_ready,
    output logic             loaded,
    input  logic             req_valid,
    input  logic [31:0]      req_addr,
    output logic             req_ready,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_inst,
    output logic             rsp_err,
    output logic [IDX_W:0]   word_count,
    output imem_state_e      state
);

    logic [IDX_W-1:0] wr_ptr;
    logic             err_q;
    logic             sel_mem_q;
    inst_t            ram_rd_data;
    imem_rsp_t        rsp;

    logic wr_en;
    logic rd_en;
    logic misaligned;
    logic out_of_range;
    logic unloaded;

    assign ld_ready  = (state == LOAD);
    assign loaded    = (state == SERVE);
    assign req_ready = (state == SERVE) && (!rsp_valid || rsp_ready);

    // reload wins over both ports in the same cycle.
    assign wr_en = ld_valid && ld_ready && !reload;
    assign rd_en = req_valid && req_ready && !reload;

    // Fetch classification; the high address bits above the index must be zero.
    assign misaligned   = (req_addr[1:0] != 2'b00);
    assign out_of_range = |req_addr[31:IDX_W+2];
    assign unloaded     = ({1'b0, req_addr[IDX_W+1:2]} >= word_count);

    imem_ram #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_idx  (wr_ptr),
        .wr_data (ld_data),
        .rd_en   (rd_en),
        .rd_idx  (req_addr[IDX_W+1:2]),
        .rd_data (ram_rd_data)
    );

    // Response payload: RAM data only for good fetches into the loaded image.
    assign rsp.inst = sel_mem_q ? ram_rd_data : NOP_WORD;
    assign rsp.err  = err_q;
    assign rsp_inst = rsp.inst;
    assign rsp_err  = rsp.err;

    // LOAD/SERVE state machine with write pointer, word count and response register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= LOAD;
            wr_ptr     <= '0;
            word_count <= '0;
            rsp_valid  <= 1'b0;
            err_q      <= 1'b0;
            sel_mem_q  <= 1'b0;
        end else if (reload) begin
            state      <= LOAD;
            wr_ptr     <= '0;
            word_count <= '0;
            rsp_valid  <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (ld_valid) begin
                        wr_ptr     <= wr_ptr + 1'b1;
                        word_count <= word_count + 1'b1;
                        // All-ones pointer is index DEPTH-1: the store is full.
                        if (ld_last || (&wr_ptr)) begin
                            state <= SERVE;
                        end
                    end
                end
                SERVE: begin
                    if (rd_en) begin
                        rsp_valid <= 1'b1;
                        err_q     <= misaligned || out_of_range;
                        sel_mem_q <= !(misaligned || out_of_range || unloaded);
                    end else if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: doc/imem_server.md
Name: imem_server

Overview:
Instruction-memory responder that sits on the far side of the fetch stage's instruction port.
- Owns the instruction store. Program image arrives as a word stream from a test or boot loader, replacing file-based preload.
- After loading, serves fetch requests with one-cycle registered read latency and a valid/ready handshake on both request and response.
- Flags misaligned and out-of-range fetches so the pipeline can trap or flush.

Parameters:
DEPTH, 1024, number of 32-bit instruction words; power of two.
IDX_W, $clog2(DEPTH), word-index width.
NOP_WORD, 32'h0000_0000, data returned for unloaded or erroring addresses.

Ports:
clk  in  1  clock; all logic on posedge.
rst  in  1  reset; synchronous, active-high.
reload  in  1  single-cycle pulse; discards the current image and re-enters LOAD.
ld_valid  in  1  load word valid.
ld_data  in  32  instruction word, written at the next sequential index.
ld_last  in  1  marks the final word of the image; qualified by ld_valid.
ld_ready  out  1  load port can accept a word.
loaded  out  1  image complete; SERVE state.
req_valid  in  1  fetch request valid.
req_addr  in  32  byte address of the instruction.
req_ready  out  1  request accepted this cycle when req_valid=1.
rsp_valid  out  1  response valid.
rsp_ready  in  1  consumer accepts the response.
rsp_inst  out  32  fetched instruction.
rsp_err  out  1  request was misaligned or out of range.
word_count  out  IDX_W+1  number of words loaded.

Behaviour:
- Reset values (rst=1): state=LOAD, wr_ptr=0, word_count=0, loaded=0, rsp_valid=0, rsp_inst=0, rsp_err=0, ld_ready=1, req_ready=0. Memory contents are not cleared. Reads at index >= word_count return NOP_WORD, so stale data is never visible.
- FSM has two states: LOAD and SERVE.
- LOAD state:
  - ld_ready=1 and req_ready=0.
  - On ld_valid&&ld_ready: mem[wr_ptr]<=ld_data, wr_ptr++, word_count++.
  - Go to SERVE when ld_last is accepted, or when the word written is at index DEPTH-1 (forced completion; no wrap).
  - loaded asserts in the cycle after the last write.
- SERVE state:
  - ld_ready=0; ld_valid is ignored.
  - req_ready = !rsp_valid || rsp_ready. This gives one response register and full throughput when rsp_ready is held at 1.
- Request accept (req_valid&&req_ready). In the next cycle rsp_valid=1 and:
  - if req_addr[1:0]!=0 → rsp_err=1, rsp_inst=NOP_WORD;
  - else if req_addr[31:2] >= DEPTH → rsp_err=1, rsp_inst=NOP_WORD;
  - else if req_addr[31:2] >= word_count → rsp_err=0, rsp_inst=NOP_WORD;
  - else → rsp_err=0, rsp_inst=mem[req_addr[IDX_W+1:2]].
- Response hold: while rsp_valid&&!rsp_ready, rsp_inst and rsp_err are held stable and req_ready=0.
- rsp_valid falls after handshake unless a new request is accepted in the same cycle (back-to-back).
- reload (any state):
  - Next cycle: state=LOAD, wr_ptr=0, word_count=0, loaded=0, rsp_valid=0.
  - Any pending response is dropped and the request accepted in the same cycle is discarded.
  - reload has priority over ld and req in the same cycle.
- rst has priority over reload.
- Memory is a single-write, single-read array, inferable as synchronous RAM. The read-during-write hazard cannot occur, because LOAD and SERVE are exclusive.

Decomposition:
- Shared package imem_pkg:
  - imem_state_e {LOAD, SERVE};
  - imem_rsp_t struct {inst, err};
  - NOP_WORD constant;
  - the existing inst_t word type is reused for memory entries.
- One sub-module, imem_ram: a DEPTH x 32 synchronous RAM with a write port and a registered read port. The FSM, counters and handshake stay in imem_server.

Test Plan:
- Load 4 words 32'h2001_0005, 32'h2002_0007, 32'h0022_1820, 32'hAC03_0000 with ld_last on the 4th → word_count=4 and loaded=1 one cycle later. Fetch addrs 0,4,8,12 back-to-back with rsp_ready=1 → those words return on consecutive cycles, rsp_err=0.
- After the 4-word load, fetch addr 16 → rsp_inst=0, rsp_err=0. Fetch addr 6 → rsp_err=1. Fetch addr 32'h0000_1000 (index 1024) → rsp_err=1.
- Hold rsp_ready=0 for 3 cycles with a request pending → rsp_inst is stable and req_ready=0 throughout. Raising rsp_ready completes the handshake, and the next request is accepted in the same cycle.
- Stream 1024 words without ld_last → loaded=1 after word 1023, ld_ready=0. A 1025th ld_valid is ignored and word_count stays 1024.
- Assert rst after 2 of 4 load words → word_count=0 and state=LOAD. Reload 1 word with ld_last, then fetch addr 4 → rsp_inst=0.
- Pulse reload in SERVE while rsp_valid=1 and rsp_ready=0 → next cycle rsp_valid=0, loaded=0, ld_ready=1, req_ready=0.
